adpcm_frame_tx: RTL
===================

# adpcm_frame_tx

Encoder-side ADPCM frame transmitter. It collects one frame of per-channel ADPCM codes from the encoder core into a double-buffered channel store. It then drives them out as 8-bit parallel words with a regenerated bit clock and frame sync, i.e. the `dec_i` / `dec_i_clk` / `dec_i_fs` stream a decoder top consumes. It sits between the encoder's output register stage and the chip pins, all in the `sysclk` domain.

## Interface

**Parameters**
- `NUM_CHN`, 8, channels per frame (2..8); `wr_addr` and the channel counter are 3 bits.
- `DIV`, 4, `clk` cycles per `tx_clk` half-period (≥2); `tx_clk` period = 2·`DIV` cycles.

**Ports**
- `clk`  in  1  system clock (`sysclk`).
- `reset`  in  1  synchronous, active-high reset.
- `RATE`  in  2  code width select: 00 = 5 bit, 01 = 4 bit, 10 = 3 bit, 11 = 2 bit.
- `wr_en`  in  1  write strobe into the back bank.
- `wr_addr`  in  3  channel index of the write.
- `wr_data`  in  5  ADPCM code I.
- `commit`  in  1  one-cycle pulse; the back bank holds a complete frame.
- `tx_data`  out  8  output word (`dec_i` side).
- `tx_clk`  out  1  regenerated word clock (`dec_i_clk` side); the receiver samples on its rising edge.
- `tx_fs`  out  1  frame sync (`dec_i_fs` side); high for the channel-0 word period.
- `underrun`  out  1  one-cycle pulse: frame boundary reached with no committed frame.

## Operation

**Storage**
- Two banks of `NUM_CHN` × 5 bits, selected by `bank_sel`.
- The front bank is read and the back bank is written.
- Writes with `wr_addr` ≥ `NUM_CHN` are ignored.

**Divider**
- `div_cnt` counts 0..`DIV`-1.
- At `div_cnt` = `DIV`-1, `tx_clk` toggles and `div_cnt` returns to 0.
- A 1→0 toggle is a launch event.

**Launch event** (all outputs registered, updated on the same `clk` edge where `tx_clk` goes low)
- If `chn_next` = 0 (frame boundary):
  - If `pending` = 1: toggle `bank_sel` and clear `pending`.
  - Else: keep `bank_sel` and pulse `underrun`. The old front frame is retransmitted.
- `tx_data` ← {3'b000, code & mask}, with code = front[`chn_next`] read after any swap.
  - mask = 5'h1F / 5'h0F / 5'h07 / 5'h03 for `RATE` 00/01/10/11.
- `tx_fs` ← (`chn_next` = 0).
- `chn_next` ← `chn_next` + 1, wrapping to 0 after `NUM_CHN`-1.

**Commit**
- `commit` sets `pending`. A `commit` while `pending` is already 1 is a no-op.
- `commit` in the same cycle as a boundary launch counts: the swap happens and `pending` ends 0.

**Writes**
- Writes always target the back bank after any swap in the same cycle (post-swap `bank_sel`).
- Writes while `pending` = 1 are allowed and ship with that frame.

**`RATE`**
- Sampled at every launch; a change takes effect at the next word.

## Timing

**Reset**
- Outputs: `tx_data` = 0, `tx_clk` = 0, `tx_fs` = 0, `underrun` = 0.
- Internal state: `div_cnt` = 0, `chn_next` = 0, `bank_sel` = 0, `pending` = 0, both banks all zero.

**After reset deassertion (cycle 0 = first edge with `reset` low)**
- `tx_clk` rises at edge `DIV`-1.
- `tx_clk` falls at edge 2·`DIV`-1; this is the first launch, of channel 0, with `tx_fs` = 1.
- With no `commit` before that edge, `underrun` pulses there and `tx_data` = 0.

**Word timing**
- Each word is stable for 2·`DIV` cycles.
- A frame lasts `NUM_CHN`·2·`DIV` cycles.

**Latency**
- Front-bank entry to `tx_data`: same edge as the launch (read is combinational from the registered bank).
- `commit` to the new data appearing: the next boundary launch.

**`reset` mid-frame**
- Everything returns to reset values on that edge.
- The partial frame is discarded and no `underrun` is produced until the first launch.

## Configuration

- **`ADPCM_TX_PARITY_EN` defined:** `tx_data[7]` = odd parity over `tx_data[6:0]`, computed after masking, so an all-zero word carries bit7 = 1.
- **Undefined:** `tx_data[7]` = 0 and `tx_data` = {3'b000, masked code}.
- The macro has no effect on any other signal or timing.

## Test plan

1. **Reset and first frame** (`DIV`=4, `NUM_CHN`=8): release reset with no writes → `tx_clk` period 8 cycles; first fall at edge 7 with `tx_fs`=1, `tx_data`=0, `underrun`=1 for one cycle.
2. **Basic frame**: write codes 5'h11..5'h18 to ch 0..7, `commit`, `RATE`=00 → at the next boundary, `tx_fs`=1 with `tx_data`=8'h11; the following words are 8'h12..8'h18; no `underrun`.
3. **Rate masking**: same frame with `RATE`=11 → words 8'h01, 8'h02, 8'h03, 8'h00, …; with `RATE`=10, ch0 = 8'h01.
4. **Underrun**: after one committed frame, no further `commit` → next boundary pulses `underrun` and the identical frame repeats.
5. **Simultaneous events**: `commit` and a write (ch3 = 5'h1F) on the boundary launch edge → swap occurs, `pending`=0, and the write appears one frame later.
6. **Mid-frame reset**: reset asserted during ch 4 → outputs zero next cycle; the timing of test 1 repeats exactly. Also run the parity build: `tx_data` 8'h00 becomes 8'h80.

Source files
------------

// File: rtl/adpcm_frame_tx.sv
// ADPCM frame transmitter: double-buffered channel store driven out as words with a
// regenerated word clock and frame sync. Define ADPCM_TX_PARITY_EN for odd parity in bit 7.
module adpcm_frame_tx #(
  parameter int unsigned NUM_CHN = 8,
  parameter int unsigned DIV     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] RATE,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       commit,
  output logic [7:0] tx_data,
  output logic       tx_clk,
  output logic       tx_fs,
  output logic       underrun
);

  localparam int unsigned DivW = $clog2(DIV);

  logic [DivW-1:0]              div_cnt_q, div_cnt_d;
  logic                         tx_clk_q, tx_clk_d;
  logic [2:0]                   chn_next_q, chn_next_d;
  logic                         bank_sel_q, bank_sel_d;
  logic                         pending_q, pending_d;
  logic [1:0][NUM_CHN-1:0][4:0] bank_q, bank_d;
  logic [7:0]                   tx_data_q, tx_data_d;
  logic                         tx_fs_q, tx_fs_d;
  logic                         underrun_q, underrun_d;

  logic       launch;
  logic       boundary;
  logic       swap;
  logic [4:0] mask;
  logic [4:0] masked;
  logic       par;

  // Divider; only the falling toggle of tx_clk launches a word.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    tx_clk_d  = tx_clk_q;
    launch    = 1'b0;
    if (div_cnt_q == DivW'(DIV - 1)) begin
      div_cnt_d = '0;
      tx_clk_d  = ~tx_clk_q;
      launch    = tx_clk_q;
    end
  end

  assign boundary = launch && (chn_next_q == 3'd0);
  // A commit landing on the boundary edge still swaps this boundary.
  assign swap     = boundary && (pending_q || commit);

  always_comb begin
    unique case (RATE)
      2'b00: mask = 5'h1F;
      2'b01: mask = 5'h0F;
      2'b10: mask = 5'h07;
      2'b11: mask = 5'h03;
    endcase
  end

  always_comb begin
    bank_sel_d = bank_sel_q ^ swap;
    masked     = bank_q[bank_sel_d][chn_next_q] & mask;
`ifdef ADPCM_TX_PARITY_EN
    par = ~^masked;
`else
    par = 1'b0;
`endif
    pending_d  = pending_q;
    if (swap) begin
      pending_d = 1'b0;
    end else if (commit) begin
      pending_d = 1'b1;
    end
    underrun_d = boundary && !swap;
    chn_next_d = chn_next_q;
    tx_data_d  = tx_data_q;
    tx_fs_d    = tx_fs_q;
    bank_d     = bank_q;
    // Writes land in the back bank as seen after this cycle's swap.
    if (wr_en && (32'(wr_addr) < NUM_CHN)) begin
      bank_d[~bank_sel_d][wr_addr] = wr_data;
    end
    if (launch) begin
      tx_data_d  = {par, 2'b00, masked};
      tx_fs_d    = (chn_next_q == 3'd0);
      chn_next_d = (chn_next_q == 3'(NUM_CHN - 1)) ? 3'd0 : chn_next_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q  <= '0;
      tx_clk_q   <= 1'b0;
      chn_next_q <= 3'd0;
      bank_sel_q <= 1'b0;
      pending_q  <= 1'b0;
      bank_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_fs_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      tx_clk_q   <= tx_clk_d;
      chn_next_q <= chn_next_d;
      bank_sel_q <= bank_sel_d;
      pending_q  <= pending_d;
      bank_q     <= bank_d;
      tx_data_q  <= tx_data_d;
      tx_fs_q    <= tx_fs_d;
      underrun_q <= underrun_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_clk   = tx_clk_q;
  assign tx_fs    = tx_fs_q;
  assign underrun = underrun_q;

endmodule
